// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and FSM state type for the AES round-key schedule controller
// Purpose : round count for AES-128, round-index width and the controller state encoding.
// Ports   : none (package).
package aes_pkg;

    localparam int NUM_ROUNDS_128 = 10;
    localparam int RK_IDX_W       = 4;

    typedef logic [1:0] aes_state_t;

    localparam aes_state_t ST_IDLE   = 2'd0;
    localparam aes_state_t ST_EXPAND = 2'd1;
    localparam aes_state_t ST_READY  = 2'd2;

endpackage

// File: rtl/aes_rk_buffer.sv
// rtl/aes_rk_buffer.sv - round-key storage, one write port and one registered read port
// Purpose : holds NUM_ROUNDS+1 round keys of BLOCK_LENGTH bits.
// Ports   : clk, rst          clock, async active-high reset (read register only)
//           i_wr_en/idx/data  write port
//           i_rd_en/idx       registered read of one slot
//           i_rd_clr          forces the read register to zero (rejected read)
//           o_rd_data         read register; holds when neither i_rd_en nor i_rd_clr
module aes_rk_buffer
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int NUM_ROUNDS   = NUM_ROUNDS_128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [RK_IDX_W-1:0]     i_wr_idx,
    input  logic [BLOCK_LENGTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    input  logic                    i_rd_clr,
    input  logic [RK_IDX_W-1:0]     i_rd_idx,
    output logic [BLOCK_LENGTH-1:0] o_rd_data
);

    // Storage is deliberately not reset; the controller gates reads with its READY state.
    logic [BLOCK_LENGTH-1:0] r_mem [0:NUM_ROUNDS];
    logic [BLOCK_LENGTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_clr) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - sequences an external key generator and buffers all round keys
// Purpose : on start, latches K0, issues rounds 0..NUM_ROUNDS to the generator, captures each
//           valid key into the buffer, then serves random-order round-key reads.
// Ports   : clk, rst                        clock, async active-high reset
//           start, key                      expansion request and cipher key K0
//           gen_en, gen_round, gen_key_init generator request side
//           gen_key, gen_valid              generator response side
//           busy, ready                     status (EXPAND / READY)
//           rk_req, rk_idx                  read request
//           rk_key, rk_valid, rk_err        registered read response
// Config  : AES_KEY_CACHE_HIT_EN - a start in READY with the already-latched key is a hit and
//           does not re-expand.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int NUM_ROUNDS   = NUM_ROUNDS_128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BLOCK_LENGTH-1:0] key,
    output logic                    gen_en,
    output logic [RK_IDX_W-1:0]     gen_round,
    output logic [BLOCK_LENGTH-1:0] gen_key_init,
    input  logic [BLOCK_LENGTH-1:0] gen_key,
    input  logic                    gen_valid,
    output logic                    busy,
    output logic                    ready,
    input  logic                    rk_req,
    input  logic [RK_IDX_W-1:0]     rk_idx,
    output logic [BLOCK_LENGTH-1:0] rk_key,
    output logic                    rk_valid,
    output logic                    rk_err
);

    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NUM_ROUNDS);

    aes_state_t              r_state;
    logic [RK_IDX_W-1:0]     r_issue_cnt;
    logic [RK_IDX_W-1:0]     r_cap_cnt;
    logic [BLOCK_LENGTH-1:0] r_key_init;
    logic                    r_rk_valid;
    logic                    r_rk_err;

    logic w_hit;
    logic w_start_acc;
    logic w_issue_act;
    logic w_cap;
    logic w_rd_ok;
    logic w_rd_bad;

`ifdef AES_KEY_CACHE_HIT_EN
    assign w_hit = (r_state == ST_READY) && (key == r_key_init);
`else
    assign w_hit = 1'b0;
`endif

    // start is only honoured from IDLE or READY; during EXPAND it is dropped.
    assign w_start_acc = start && !w_hit && ((r_state == ST_IDLE) || (r_state == ST_READY));
    assign w_issue_act = (r_state == ST_EXPAND) && (r_issue_cnt <= LAST_IDX);
    assign w_cap       = (r_state == ST_EXPAND) && gen_valid;

    // Reads resolve against the pre-edge state, so a read alongside a re-start sees old keys.
    assign w_rd_ok  = rk_req && (r_state == ST_READY) && (rk_idx <= LAST_IDX);
    assign w_rd_bad = rk_req && !w_rd_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_key_init  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (w_start_acc) begin
                        r_key_init  <= key;
                        r_issue_cnt <= '0;
                        r_cap_cnt   <= '0;
                        r_state     <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    // Issue runs ahead independently of capture; a stalled generator only
                    // delays capture, it never rewinds issue.
                    if (w_issue_act) begin
                        r_issue_cnt <= r_issue_cnt + RK_IDX_W'(1);
                    end
                    if (w_cap) begin
                        r_cap_cnt <= r_cap_cnt + RK_IDX_W'(1);
                        if (r_cap_cnt == LAST_IDX) begin
                            r_state <= ST_READY;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rk_valid <= 1'b0;
            r_rk_err   <= 1'b0;
        end else begin
            r_rk_valid <= w_rd_ok;
            r_rk_err   <= w_rd_bad;
        end
    end

    aes_rk_buffer #(
        .BLOCK_LENGTH (BLOCK_LENGTH),
        .NUM_ROUNDS   (NUM_ROUNDS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_cap),
        .i_wr_idx  (r_cap_cnt),
        .i_wr_data (gen_key),
        .i_rd_en   (w_rd_ok),
        .i_rd_clr  (w_rd_bad),
        .i_rd_idx  (rk_idx),
        .o_rd_data (rk_key)
    );

    assign gen_en       = w_issue_act;
    assign gen_round    = w_issue_act ? r_issue_cnt : '0;
    assign gen_key_init = r_key_init;
    assign busy         = (r_state == ST_EXPAND);
    assign ready        = (r_state == ST_READY);
    assign rk_valid     = r_rk_valid;
    assign rk_err       = r_rk_err;

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_LENGTH, default 128, round-key width in bits.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, last round index; the buffer holds NUM_ROUNDS+1 keys.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request to expand key; sampled on the clock edge.
REQ-007 key  input  BLOCK_LENGTH  cipher key K0, sampled when start is accepted.
REQ-008 gen_en  output  1  enable to the key generator.
REQ-009 gen_round  output  4  Round_Count to the key generator.
REQ-010 gen_key_init  output  BLOCK_LENGTH  latched K0 to the generator key input.
REQ-011 gen_key  input  BLOCK_LENGTH  generator current_key.
REQ-012 gen_valid  input  1  generator key_valid.
REQ-013 busy  output  1  expansion in progress.
REQ-014 ready  output  1  all NUM_ROUNDS+1 keys buffered.
REQ-015 rk_req  input  1  read request.
REQ-016 rk_idx  input  4  requested round index; decryption reads NUM_ROUNDS down to 0.
REQ-017 rk_key  output  BLOCK_LENGTH  registered read data.
REQ-018 rk_valid  output  1  one-cycle pulse, rk_key valid.
REQ-019 rk_err  output  1  one-cycle pulse, rejected read.

Function
REQ-020 SHALL implement the FSM IDLE, EXPAND, READY; reset state is IDLE.
REQ-021 IDLE: start=1 latches key into gen_key_init, clears issue and capture counters, and goes to EXPAND.
REQ-022 EXPAND: gen_en=1 with gen_round = issue counter for issue counts 0..NUM_ROUNDS, one per cycle; gen_en=0 afterwards.
REQ-023 EXPAND: each cycle with gen_valid=1 writes gen_key to buffer slot = capture counter, then increments the counter.
REQ-024 Writing slot NUM_ROUNDS moves the FSM to READY; with a 1-cycle generator, ready rises 12 edges after the edge that accepted start.
REQ-025 gen_valid=0 in EXPAND stalls capture without error; the issue counter is not rewound.
REQ-026 busy=1 exactly in EXPAND; ready=1 exactly in READY.
REQ-027 start during EXPAND SHALL be ignored.
REQ-028 start in READY SHALL re-enter EXPAND; ready drops on the next edge.
REQ-029 rk_req in READY with rk_idx<=NUM_ROUNDS: rk_key = slot rk_idx and rk_valid=1 on the next edge.
REQ-030 rk_req with rk_idx>NUM_ROUNDS, or rk_req outside READY: rk_err=1 and rk_valid=0 on the next edge, with rk_key=0.
REQ-031 rk_req in the same cycle as an accepted start in READY SHALL be served from the old buffer contents.
REQ-032 rk_key SHALL hold its last value when no read occurs.

Reset
REQ-033 rst SHALL force IDLE, busy=0, ready=0, gen_en=0, gen_round=0, gen_key_init=0, rk_key=0, rk_valid=0, rk_err=0, and all counters to 0.
REQ-034 Buffer contents are not reset; ready=0 gates all reads.
REQ-035 rst mid-EXPAND SHALL abort expansion; a new start is required.

Configuration
REQ-036 The macro is AES_KEY_CACHE_HIT_EN.
REQ-037 With AES_KEY_CACHE_HIT_EN defined: start in READY with key equal to the latched K0 is a hit; state stays READY, ready stays 1, and no gen_en is issued.
REQ-038 With AES_KEY_CACHE_HIT_EN defined: an accepted start in IDLE, or in READY with a different key, behaves as REQ-021/REQ-028.
REQ-039 Without the macro, every start in IDLE or READY expands, and no comparator is built.

Structure
REQ-040 Package aes_pkg SHALL hold NUM_ROUNDS_128=10, RK_IDX_W=4, and the FSM state typedef.
REQ-041 The buffer SHALL be sub-module aes_rk_buffer: NUM_ROUNDS+1 x BLOCK_LENGTH registers, one write port, one registered read port.

Verification
REQ-042 Scenario: start with key 2b7e151628aed2a6abf7158809cf4f3c -> ready after 12 edges; read idx 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6, and idx 0 gives K0.
REQ-043 Scenario: reads idx 10..0 back-to-back -> 11 consecutive rk_valid pulses matching FIPS-197 A.1 keys in order.
REQ-044 Scenario: rk_idx=11 in READY, or rk_req in EXPAND -> rk_err pulse, rk_valid=0, rk_key=0.
REQ-045 Scenario: rst asserted after the 5th capture -> outputs at reset values; a new start completes normally.
REQ-046 Scenario: gen_valid held low 3 cycles mid-EXPAND -> ready delayed by 3 cycles, keys still correct.
REQ-047 Scenario with AES_KEY_CACHE_HIT_EN: repeat start with the same key -> ready stays 1 and no gen_en; different key -> re-expansion.
